change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/vend_pkg.sv | 41 ++++
 rtl/coin_hopper.sv | 33 +++
 rtl/change_dispenser.sv | 144 ++++++++++++++
 tb/tb_change_dispenser.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// vend_pkg: shared definitions for the change dispenser.
//   state_t      payout FSM states
//   coin_t       denomination select, encoded the same way as refill_sel
//   VAL_*        coin face values in units
//   REFILL_*     refill_sel encodings (2'b00 matches none and is ignored)
//   coin_value() maps a coin_t to its face value
package vend_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_PULSE  = 3'd2,
    S_GAP    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_1    = 2'b01,
    COIN_2    = 2'b10,
    COIN_5    = 2'b11
  } coin_t;

  localparam logic [3:0] VAL_1 = 4'd1;
  localparam logic [3:0] VAL_2 = 4'd2;
  localparam logic [3:0] VAL_5 = 4'd5;

  localparam logic [1:0] REFILL_1 = 2'b01;
  localparam logic [1:0] REFILL_2 = 2'b10;
  localparam logic [1:0] REFILL_5 = 2'b11;

  function automatic logic [3:0] coin_value(input coin_t c);
    case (c)
      COIN_1:  coin_value = VAL_1;
      COIN_2:  coin_value = VAL_2;
      COIN_5:  coin_value = VAL_5;
      default: coin_value = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/coin_hopper.sv
// coin_hopper: occupancy counter for one coin tube.
//   clock, reset  rising-edge clock, async active-high reset
//   init_val      count loaded while reset is asserted
//   inc           one coin added (refill); dropped when already at DEPTH
//   dec           one coin ejected; never wraps below 0
//   cnt           current occupancy
module coin_hopper #(
  parameter int DEPTH = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] init_val,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] cnt
);

  localparam logic [3:0] MAX = 4'(DEPTH);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= init_val;
    end else if (inc && dec) begin
      // refill and payout cancel, unless the refill coin is dropped at full
      if (cnt == MAX) cnt <= cnt - 4'd1;
    end else if (inc) begin
      if (cnt != MAX) cnt <= cnt + 4'd1;
    end else if (dec) begin
      if (cnt != 4'd0) cnt <= cnt - 4'd1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays out change greedily from 5/2/1-unit hoppers.
//   clock, reset          rising-edge clock, async active-high reset
//   change_valid/amount   change request; accepted when change_ready (IDLE)
//   change_ready, busy    IDLE / not IDLE
//   refill_valid/sel      add one coin to the selected hopper, any state
//   coin_1/2/5            one-cycle eject pulses, at most one per cycle
//   done                  one-cycle end-of-payout pulse
//   shortfall             units left unpaid by the last request
//   cnt_1/2/5             hopper occupancy
//   total_paid            value of all ejected coins (saturating) when built
//                         with CHANGE_DISPENSER_AUDIT_EN, otherwise 0
//
// state  | meaning
// IDLE   | waiting for a request
// SELECT | pick largest coin <= remaining with stock, or finish
// PULSE  | eject the selected coin
// GAP    | PAYOUT_GAP idle cycles between coins
// DONE   | done pulse, back to IDLE
module change_dispenser
  import vend_pkg::*;
#(
  parameter int HOPPER_DEPTH = 15,
  parameter int HOPPER_INIT  = 4,
  parameter int PAYOUT_GAP   = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       change_valid,
  input  logic [3:0] change_amount,
  output logic       change_ready,
  input  logic       refill_valid,
  input  logic [1:0] refill_sel,
  output logic       coin_1,
  output logic       coin_2,
  output logic       coin_5,
  output logic       busy,
  output logic       done,
  output logic [3:0] shortfall,
  output logic [3:0] cnt_1,
  output logic [3:0] cnt_2,
  output logic [3:0] cnt_5,
  output logic [7:0] total_paid
);

  localparam logic [3:0] INIT_CNT = 4'(HOPPER_INIT);
  // GAP is entered with the count of cycles still to wait after this one
  localparam logic [7:0] GAP_LOAD = (PAYOUT_GAP > 0) ? 8'(PAYOUT_GAP - 1) : 8'd0;

  state_t     state;
  coin_t      sel;
  coin_t      pick;
  logic [3:0] remaining;
  logic [7:0] gap_cnt;

  always_comb begin
    pick = COIN_NONE;
    if (remaining >= VAL_5 && cnt_5 != 4'd0)      pick = COIN_5;
    else if (remaining >= VAL_2 && cnt_2 != 4'd0) pick = COIN_2;
    else if (remaining >= VAL_1 && cnt_1 != 4'd0) pick = COIN_1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      sel       <= COIN_NONE;
      remaining <= 4'd0;
      shortfall <= 4'd0;
      gap_cnt   <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (change_valid) begin
            remaining <= change_amount;
            shortfall <= 4'd0;
            state     <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (pick == COIN_NONE) begin
            shortfall <= remaining;
            state     <= S_DONE;
          end else begin
            sel   <= pick;
            state <= S_PULSE;
          end
        end
        S_PULSE: begin
          remaining <= remaining - coin_value(sel);
          if (PAYOUT_GAP == 0) begin
            state <= S_SELECT;
          end else begin
            gap_cnt <= GAP_LOAD;
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == 8'd0) state <= S_SELECT;
          else                 gap_cnt <= gap_cnt - 8'd1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign change_ready = (state == S_IDLE);
  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);
  assign coin_1       = (state == S_PULSE) && (sel == COIN_1);
  assign coin_2       = (state == S_PULSE) && (sel == COIN_2);
  assign coin_5       = (state == S_PULSE) && (sel == COIN_5);

  coin_hopper #(.DEPTH(HOPPER_DEPTH)) u_hopper_1 (
    .clock(clock), .reset(reset), .init_val(INIT_CNT),
    .inc(refill_valid && refill_sel == REFILL_1), .dec(coin_1), .cnt(cnt_1)
  );

  coin_hopper #(.DEPTH(HOPPER_DEPTH)) u_hopper_2 (
    .clock(clock), .reset(reset), .init_val(INIT_CNT),
    .inc(refill_valid && refill_sel == REFILL_2), .dec(coin_2), .cnt(cnt_2)
  );

  coin_hopper #(.DEPTH(HOPPER_DEPTH)) u_hopper_5 (
    .clock(clock), .reset(reset), .init_val(INIT_CNT),
    .inc(refill_valid && refill_sel == REFILL_5), .dec(coin_5), .cnt(cnt_5)
  );

`ifdef CHANGE_DISPENSER_AUDIT_EN
  logic [7:0] paid_q;
  logic [8:0] paid_sum;

  assign paid_sum = {1'b0, paid_q} + {5'd0, coin_value(sel)};

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                  paid_q <= 8'd0;
    else if (state == S_PULSE)  paid_q <= paid_sum[8] ? 8'hFF : paid_sum[7:0];
  end

  assign total_paid = paid_q;
`else
  assign total_paid = 8'd0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;
  import vend_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       change_valid = 1'b0;
  logic [3:0] change_amount = 4'd0;
  logic       change_ready;
  logic       refill_valid = 1'b0;
  logic [1:0] refill_sel = 2'b00;
  logic       coin_1, coin_2, coin_5, busy, done;
  logic [3:0] shortfall, cnt_1, cnt_2, cnt_5;
  logic [7:0] total_paid;

  change_dispenser dut (
    .clock(clock), .reset(reset),
    .change_valid(change_valid), .change_amount(change_amount),
    .change_ready(change_ready),
    .refill_valid(refill_valid), .refill_sel(refill_sel),
    .coin_1(coin_1), .coin_2(coin_2), .coin_5(coin_5),
    .busy(busy), .done(done), .shortfall(shortfall),
    .cnt_1(cnt_1), .cnt_2(cnt_2), .cnt_5(cnt_5),
    .total_paid(total_paid)
  );

  always #5 clock = ~clock;

  int pass_cnt = 0;
  int total_cnt = 0;
  int exp_q[$];
  int exp_paid = 0;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Scoreboard: every observed coin must match the next expected value.
  always @(negedge clock) begin
    if (!reset && (coin_1 || coin_2 || coin_5)) begin
      int v;
      check("coin_onehot", int'(coin_1) + int'(coin_2) + int'(coin_5), 1);
      v = coin_5 ? 5 : (coin_2 ? 2 : 1);
      if (exp_q.size() == 0) check("coin_unexpected", v, 0);
      else check("coin_value", v, exp_q.pop_front());
    end
  end

  function automatic int exp_total();
`ifdef CHANGE_DISPENSER_AUDIT_EN
    return (exp_paid > 255) ? 255 : exp_paid;
`else
    return 0;
`endif
  endfunction

  typedef struct {
    int         refill1;
    logic [3:0] amount;
    int         n;
    logic [31:0] seq;      // nibble i = value of coin i
    int         done_cyc;  // cycle of done, cycle 1 = first after handshake
    logic [3:0] sf;
    logic [3:0] c1, c2, c5;
  } vec_t;

  vec_t vecs[7];

  task automatic refill(input logic [1:0] s);
    @(negedge clock);
    refill_valid = 1'b1;
    refill_sel = s;
    @(negedge clock);
    refill_valid = 1'b0;
    refill_sel = 2'b00;
  endtask

  task automatic run_req(input vec_t v);
    int cyc, first, second, done_at;
    logic [31:0] s;
    for (int i = 0; i < v.refill1; i++) refill(REFILL_1);
    s = v.seq;
    for (int i = 0; i < v.n; i++) begin
      exp_q.push_back(int'(s[4*i +: 4]));
      exp_paid += int'(s[4*i +: 4]);
    end
    @(negedge clock);
    check("ready_before_req", int'(change_ready), 1);
    change_valid = 1'b1;
    change_amount = v.amount;
    @(posedge clock);
    @(negedge clock);
    change_valid = 1'b0;
    cyc = 1; first = 0; second = 0; done_at = 0;
    while (cyc < 200 && done_at == 0) begin
      if (coin_1 || coin_2 || coin_5) begin
        if (first == 0) first = cyc;
        else if (second == 0) second = cyc;
      end
      if (done) done_at = cyc;
      else begin
        @(negedge clock);
        cyc++;
      end
    end
    check("done_cycle", done_at, v.done_cyc);
    if (v.n >= 1) check("first_coin_cycle", first, 2);
    if (v.n >= 2) check("coin_spacing", second - first, 3);
    check("shortfall", int'(shortfall), int'(v.sf));
    check("cnt_1", int'(cnt_1), int'(v.c1));
    check("cnt_2", int'(cnt_2), int'(v.c2));
    check("cnt_5", int'(cnt_5), int'(v.c5));
    check("coins_all_seen", exp_q.size(), 0);
    check("total_paid", int'(total_paid), exp_total());
    @(negedge clock);
    check("shortfall_held", int'(shortfall), int'(v.sf));
  endtask

  // 5-unit payout with a 5-unit refill landing on the same edge as the eject.
  task automatic pay5_with_refill(input bit hold_valid, input int exp_c5);
    int cyc;
    exp_q.push_back(5);
    exp_paid += 5;
    @(negedge clock);
    change_valid = 1'b1;
    change_amount = 4'd5;
    @(posedge clock);
    @(negedge clock);                          // SELECT
    if (hold_valid) change_amount = 4'd15;     // must be ignored while busy
    else change_valid = 1'b0;
    @(negedge clock);                          // PULSE
    check("pulse_coin_5", int'(coin_5), 1);
    refill_valid = 1'b1;
    refill_sel = REFILL_5;
    @(negedge clock);
    refill_valid = 1'b0;
    refill_sel = 2'b00;
    check("cnt_5_refill_and_pay", int'(cnt_5), exp_c5);
    cyc = 0;
    while (!done && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    check("done_seen", int'(done), 1);
    change_valid = 1'b0;
    check("shortfall_after_5", int'(shortfall), 0);
    check("coins_all_seen_5", exp_q.size(), 0);
  endtask

  initial begin
    vec_t v;
    int cyc;
    //           refill amt  n  seq           done sf c1 c2 c5
    vecs[0] = '{0, 4'd7,  2, 32'h25,       8,  4'd0, 4'd4, 4'd3, 4'd3};
    vecs[1] = '{0, 4'd0,  0, 32'h0,        2,  4'd0, 4'd4, 4'd3, 4'd3};
    vecs[2] = '{0, 4'd15, 3, 32'h555,      11, 4'd0, 4'd4, 4'd3, 4'd0};
    vecs[3] = '{0, 4'd9,  6, 32'h111222,   20, 4'd0, 4'd1, 4'd0, 4'd0};
    vecs[4] = '{0, 4'd4,  1, 32'h1,        5,  4'd3, 4'd0, 4'd0, 4'd0};
    vecs[5] = '{0, 4'd3,  0, 32'h0,        2,  4'd3, 4'd0, 4'd0, 4'd0};
    vecs[6] = '{4, 4'd4,  4, 32'h1111,     14, 4'd0, 4'd0, 4'd0, 4'd0};

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_ready", int'(change_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_coins", int'(coin_1) + int'(coin_2) + int'(coin_5), 0);
    check("rst_shortfall", int'(shortfall), 0);
    check("rst_cnt_1", int'(cnt_1), 4);
    check("rst_cnt_2", int'(cnt_2), 4);
    check("rst_cnt_5", int'(cnt_5), 4);
    check("rst_total_paid", int'(total_paid), 0);

    for (int i = 0; i < 7; i++) run_req(vecs[i]);

    refill(2'b00);
    check("refill_sel_00_ignored", int'(cnt_1) + int'(cnt_2) + int'(cnt_5), 0);
    for (int i = 0; i < 4; i++) refill(REFILL_1);
    check("cnt_1_refilled_4", int'(cnt_1), 4);
    for (int i = 0; i < 15; i++) refill(REFILL_1);
    check("cnt_1_saturated", int'(cnt_1), 15);

    refill(REFILL_5);
    refill(REFILL_5);
    check("cnt_5_refilled_2", int'(cnt_5), 2);
    pay5_with_refill(1'b1, 2);
    for (int i = 0; i < 13; i++) refill(REFILL_5);
    check("cnt_5_full", int'(cnt_5), 15);
    pay5_with_refill(1'b0, 14);
    check("total_paid_after_5s", int'(total_paid), exp_total());

    // Reset during the first GAP of a 12-unit payout (5,5,2).
    exp_q.push_back(5); exp_q.push_back(5); exp_q.push_back(2);
    @(negedge clock);
    change_valid = 1'b1;
    change_amount = 4'd12;
    @(posedge clock);
    @(negedge clock);
    change_valid = 1'b0;
    @(negedge clock);                          // PULSE, first 5 popped
    @(negedge clock);                          // GAP
    check("gap_busy", int'(busy), 1);
    check("gap_no_coin", int'(coin_1) + int'(coin_2) + int'(coin_5), 0);
    reset = 1'b1;
    #1;
    check("mid_rst_ready", int'(change_ready), 1);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_coins", int'(coin_1) + int'(coin_2) + int'(coin_5), 0);
    check("mid_rst_shortfall", int'(shortfall), 0);
    check("mid_rst_cnt_1", int'(cnt_1), 4);
    check("mid_rst_cnt_2", int'(cnt_2), 4);
    check("mid_rst_cnt_5", int'(cnt_5), 4);
    check("mid_rst_total_paid", int'(total_paid), 0);
    check("mid_rst_one_coin_out", exp_q.size(), 2);
    exp_q.delete();
    exp_paid = 0;
    @(negedge clock);
    reset = 1'b0;
    cyc = 0;
    repeat (3) begin
      @(negedge clock);
      cyc += int'(busy);
    end
    check("idle_after_rst", cyc, 0);

    // Audit accumulation over a 7 then a 4 request from fresh hoppers.
    v = '{0, 4'd7, 2, 32'h25, 8, 4'd0, 4'd4, 4'd3, 4'd3};
    run_req(v);
    v = '{0, 4'd4, 2, 32'h22, 8, 4'd0, 4'd4, 4'd1, 4'd3};
    run_req(v);
`ifdef CHANGE_DISPENSER_AUDIT_EN
    check("audit_7_plus_4", int'(total_paid), 11);
`else
    check("audit_disabled", int'(total_paid), 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
